// File: rtl/max_pool_2x2.sv
// Streaming 2x2/stride-2 signed max-pool over a row-major m x n tile, one word per handshake.
// Latency: pooled word valid one cycle after the fourth contributing input is accepted.
// Backpressure: in_ready drops while a pooled word is held and out_ready is low.
module max_pool_2x2 #(
    parameter int DW       = 16,
    parameter int MAX_COLS = 30
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [4:0]    m,
    input  logic [4:0]    n,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    input  logic          out_ready,
    output logic          done,
    output logic          err
);

    localparam int LB_DEPTH = MAX_COLS / 2;
    localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
    localparam logic [4:0] MAX_N = 5'(MAX_COLS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [4:0]       m_q, n_q;
    logic [4:0]       r, c;
    logic [DW-1:0]    p;
    logic             err_q;
    logic [DW-1:0]    line_buf [LB_DEPTH];
    logic [LB_AW-1:0] lb_idx;

    logic          dims_bad;
    logic          accept;
    logic          at_end;
    logic          load;
    logic [DW-1:0] pair_max;
    logic [DW-1:0] pool_max;

    function automatic logic [DW-1:0] smax(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return ($signed(a) >= $signed(b)) ? a : b;
    endfunction

    assign dims_bad = (m == 5'd0) || (n == 5'd0) || m[0] || n[0] || (n > MAX_N);
    assign accept   = in_valid && in_ready;
    assign at_end   = (r == m_q - 5'd1) && (c == n_q - 5'd1);
    assign load     = accept && r[0] && c[0];
    assign lb_idx   = LB_AW'(c >> 1);
    assign pair_max = smax(p, in_data);
    // Odd rows fold in the pair maximum saved from the even row above.
    assign pool_max = smax(pair_max, line_buf[lb_idx]);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = dims_bad ? S_FIN : S_RUN;
                end
            end
            S_RUN: begin
                if (accept && at_end) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (out_valid && out_ready && out_last) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q == S_RUN) && (!out_valid || out_ready);
        done     = (state_q == S_FIN);
        err      = (state_q == S_FIN) && err_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m_q   <= '0;
            n_q   <= '0;
            err_q <= 1'b0;
            r     <= '0;
            c     <= '0;
            p     <= '0;
        end else if (state_q == S_IDLE && start) begin
            m_q   <= m;
            n_q   <= n;
            err_q <= dims_bad;
            r     <= '0;
            c     <= '0;
        end else if (accept) begin
            if (!c[0]) begin
                p <= in_data;
            end
            if (c == n_q - 5'd1) begin
                c <= '0;
                r <= r + 5'd1;
            end else begin
                c <= c + 5'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept && !r[0] && c[0]) begin
            line_buf[lb_idx] <= pair_max;
        end
    end

    // A fresh result wins over the handshake clear, keeping out_valid high back-to-back.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= pool_max;
            out_last  <= at_end;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_max_pool_2x2.sv
// Scoreboard bench for max_pool_2x2: a tile-level reference model queues expected pooled words,
// an independent monitor pops and compares on every output handshake.
module tb_max_pool_2x2;

    localparam int DW = 16;

    logic          clk;
    logic          reset;
    logic          start;
    logic [4:0]    m, n;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          out_ready;
    logic          done;
    logic          err;

    max_pool_2x2 #(.DW(DW), .MAX_COLS(30)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .m         (m),
        .n         (n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int out_total = 0;
    int last_hs_cyc = 0;
    int done_cnt = 0;

    logic [DW:0]   exp_q[$];
    logic [DW-1:0] tile [0:31][0:31];

    // 0: always ready, 1: random, 2: manual_rdy
    int   rdy_mode = 0;
    logic manual_rdy = 1'b1;
    logic rnd_rdy = 1'b1;
    assign out_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? rnd_rdy : manual_rdy;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) rnd_rdy = ($urandom_range(0, 3) != 0);

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    always @(negedge clk) begin
        #4;
        if (!reset && out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 32'(out_valid), 32'd0);
            end else if (out_ready) begin
                logic [DW:0] e;
                e = exp_q.pop_front();
                check("out_data", 32'(out_data), 32'(e[DW-1:0]));
                check("out_last", 32'(out_last), 32'(e[DW]));
                out_total++;
                if (out_last) last_hs_cyc = cyc;
            end
        end
        if (done) done_cnt++;
    end

    // Reference: each pooled word is the signed maximum of its 2x2 window.
    task automatic push_expected(input int mm, input int nn);
        for (int i = 0; i < mm / 2; i++) begin
            for (int j = 0; j < nn / 2; j++) begin
                int best;
                best = -1000000;
                for (int di = 0; di < 2; di++)
                    for (int dj = 0; dj < 2; dj++)
                        if (int'($signed(tile[2*i+di][2*j+dj])) > best)
                            best = int'($signed(tile[2*i+di][2*j+dj]));
                exp_q.push_back({(i == mm/2 - 1) && (j == nn/2 - 1), 16'(best)});
            end
        end
    endtask

    function automatic bit legal(input int mm, input int nn);
        return mm > 0 && nn > 0 && (mm % 2 == 0) && (nn % 2 == 0) && nn <= 30;
    endfunction

    task automatic pulse_start(input int mm, input int nn);
        @(negedge clk);
        m = 5'(mm);
        n = 5'(nn);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drive(input int nn, input int limit, input bit gaps);
        int idx;
        int guard;
        idx = 0;
        guard = 0;
        while (idx < limit && guard < 20000) begin
            @(negedge clk);
            guard++;
            in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_data  = tile[idx / nn][idx % nn];
            #4;
            if (in_valid && in_ready) idx++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        if (idx < limit) check("input_timeout", 32'(idx), 32'(limit));
    endtask

    task automatic end_tile(input int out_base, input int exp_outs, input bit exp_err, input bit chk_lat);
        bit found;
        int dc;
        found = 1'b0;
        for (int g = 0; g < 3000; g++) begin
            #4;
            if (done) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("done_seen", 32'(found), 32'd1);
        if (found) begin
            dc = cyc;
            check("err", 32'(err), 32'(exp_err));
            if (chk_lat) check("done_latency", 32'(dc - last_hs_cyc), 32'd1);
            @(negedge clk);
            #4;
            check("done_width", 32'(done), 32'd0);
        end
        check("out_count", 32'(out_total - out_base), 32'(exp_outs));
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
    endtask

    task automatic run_tile(input int mm, input int nn, input bit gaps);
        int base;
        bit ok;
        base = out_total;
        ok = legal(mm, nn);
        if (ok) push_expected(mm, nn);
        pulse_start(mm, nn);
        if (ok) drive(nn, mm * nn, gaps);
        end_tile(base, ok ? (mm / 2) * (nn / 2) : 0, !ok, ok);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int dsave;
        reset = 1'b1;
        start = 1'b0;
        m = '0;
        n = '0;
        in_valid = 1'b0;
        in_data = '0;
        repeat (3) @(negedge clk);
        #4;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Basic 4x4, values 1..16 -> 6, 8, 14, 16
        for (int i = 0; i < 16; i++) tile[i / 4][i % 4] = 16'(i + 1);
        rdy_mode = 0;
        run_tile(4, 4, 1'b0);

        // Signed 2x2 -> -3
        tile[0][0] = -16'sd5; tile[0][1] = -16'sd3;
        tile[1][0] = -16'sd9; tile[1][1] = -16'sd4;
        run_tile(2, 2, 1'b0);

        // Backpressure: hold first result (6) for 5 cycles
        for (int i = 0; i < 16; i++) tile[i / 4][i % 4] = 16'(i + 1);
        rdy_mode = 2;
        manual_rdy = 1'b0;
        base = out_total;
        push_expected(4, 4);
        pulse_start(4, 4);
        fork
            drive(4, 16, 1'b0);
            begin
                int g;
                g = 0;
                do begin
                    @(negedge clk);
                    #4;
                    g++;
                end while (!out_valid && g < 200);
                check("bp_valid_seen", 32'(out_valid), 32'd1);
                for (int k = 0; k < 5; k++) begin
                    if (k > 0) begin
                        @(negedge clk);
                        #4;
                    end
                    check("bp_hold_data", 32'(out_data), 32'd6);
                    check("bp_hold_valid", 32'(out_valid), 32'd1);
                    check("bp_in_ready", 32'(in_ready), 32'd0);
                end
                @(negedge clk);
                manual_rdy = 1'b1;
            end
        join
        end_tile(base, 4, 1'b0, 1'b1);
        rdy_mode = 0;

        // Illegal dimensions
        run_tile(3, 4, 1'b0);
        run_tile(4, 0, 1'b0);
        run_tile(0, 2, 1'b0);
        run_tile(4, 5, 1'b0);
        run_tile(2, 31, 1'b0);

        // Start while busy is ignored
        for (int i = 0; i < 16; i++) tile[i / 4][i % 4] = 16'(100 - 3 * i);
        base = out_total;
        push_expected(4, 4);
        pulse_start(4, 4);
        fork
            drive(4, 16, 1'b0);
            begin
                repeat (5) @(negedge clk);
                m = 5'd2;
                n = 5'd2;
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        join
        end_tile(base, 4, 1'b0, 1'b1);

        // Reset after 6 inputs of a 4x4 tile
        for (int i = 0; i < 16; i++) tile[i / 4][i % 4] = 16'(i + 1);
        rdy_mode = 2;
        manual_rdy = 1'b0;
        push_expected(4, 4);
        pulse_start(4, 4);
        drive(4, 6, 1'b0);
        dsave = done_cnt;
        reset = 1'b1;
        @(negedge clk);
        #4;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_data", 32'(out_data), 32'd0);
        check("midrst_out_last", 32'(out_last), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        rdy_mode = 0;
        repeat (4) @(negedge clk);
        check("midrst_no_done", 32'(done_cnt), 32'(dsave));
        tile[0][0] = 16'd7; tile[0][1] = 16'd1;
        tile[1][0] = 16'd2; tile[1][1] = 16'd3;
        run_tile(2, 2, 1'b0);

        // Widest tile with extreme values and ties
        for (int j = 0; j < 30; j++) begin
            tile[0][j] = (j % 3 == 0) ? 16'h8000 : 16'h7FFF;
            tile[1][j] = (j % 4 == 0) ? 16'h7FFF : 16'h8000;
        end
        rdy_mode = 1;
        run_tile(2, 30, 1'b1);

        // Randomized legal tiles with random gaps and backpressure
        for (int t = 0; t < 10; t++) begin
            int mm;
            int nn;
            mm = 2 * $urandom_range(1, 4);
            nn = 2 * $urandom_range(1, 15);
            for (int i = 0; i < mm; i++)
                for (int j = 0; j < nn; j++)
                    tile[i][j] = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
            rdy_mode = $urandom_range(0, 1);
            run_tile(mm, nn, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/max_pool_2x2.md
Name: max_pool_2x2

Overview:
- Streaming 2x2, stride-2 max-pooling stage sitting directly downstream of the activation unit in TinyML.
- Consumes an m x n activation tile in row-major order, one word per handshake.
- Emits an (m/2) x (n/2) pooled tile in row-major order toward the unified-buffer write-back path.
- Uses one half-row line buffer to hold pair maxima of even rows.

Parameters:
- DW, 16, data word width; values are two's-complement signed.
- MAX_COLS, 30, maximum supported n; sets line-buffer depth to MAX_COLS/2.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; latches m and n, begins a tile
- m  in  5  tile rows
- n  in  5  tile columns
- in_valid  in  1  activation word valid
- in_data  in  DW  activation word (signed)
- in_ready  out  1  stage accepts in_data this cycle
- out_valid  out  1  pooled word valid
- out_data  out  DW  pooled word (signed)
- out_last  out  1  marks final pooled word of tile
- out_ready  in  1  consumer accepts out_data
- done  out  1  one-cycle pulse at tile end
- err  out  1  one-cycle pulse with done when dimensions are illegal

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values: in_ready=0, out_valid=0, out_data=0, out_last=0, done=0, err=0. State returns to IDLE and all counters are cleared.
- Reset mid-tile aborts the tile; no done pulse is issued. Line-buffer contents need not be cleared.
- States: IDLE, RUN, FLUSH, FIN.
- IDLE: on start, latch m and n.
  - If m==0, n==0, m odd, n odd, or n>MAX_COLS: go to FIN with err set.
  - Otherwise clear row/col counters and go to RUN.
- start is ignored outside IDLE.
- RUN: in_ready = !out_valid || out_ready. An input is accepted when in_valid && in_ready.
- Column counter c wraps at n-1 and increments the row counter r. Pair register p holds the element at even c.
- Even r, odd c: line_buf[c/2] <= max(p, in_data).
- Odd r, odd c: out_data <= max(max(p, in_data), line_buf[c/2]). Set out_valid=1 the next cycle (one-cycle latency after the fourth element is accepted).
- out_last = 1 when that input had r==m-1 and c==n-1.
- max is a signed comparison; ties yield the shared value.
- out_valid and out_data hold stable until out_ready; the output clears on handshake unless a new result loads in the same cycle.
- After the last input is accepted, go to FLUSH with in_ready=0.
- FLUSH: wait for the out_last handshake, then go to FIN.
- FIN: done=1 for exactly one cycle (err=1 too if dimensions were illegal), then go to IDLE.
- Simultaneous out handshake and new result: the new result loads; out_valid stays 1.
- Pooled output count per tile is exactly (m/2)*(n/2).

Test Plan:
- Basic 4x4: m=4, n=4; rows [1 2 3 4],[5 6 7 8],[9 10 11 12],[13 14 15 16], out_ready=1 -> outputs 6, 8, 14, 16; out_last on 16; done one cycle after the 16 handshake; err=0.
- Signed values: 2x2 tile [-5 -3],[-9 -4] -> single output -3 with out_last=1.
- Backpressure: 4x4 tile, out_ready low for 5 cycles after the first out_valid -> out_data holds 6 stable, in_ready=0 while blocked, no data lost, sequence unchanged.
- Illegal dims: start with m=3, n=4 -> no out_valid; done=1 and err=1 in the same single cycle; back to IDLE.
- Start while busy: second start mid-tile with m=2, n=2 -> ignored; first tile completes with its original count of 4 outputs.
- Reset mid-tile: assert reset after 6 inputs of a 4x4 tile -> all outputs 0 next cycle, no done pulse; a following 2x2 tile [7 1],[2 3] pools to 7 correctly.
